// File: rtl/mil1553_pkg.sv
// MIL-STD-1553 shared constants and the Manchester II frame builder.
package mil1553_pkg;

  localparam int unsigned SYNC_HALF_BITS  = 6;
  localparam int unsigned DATA_BITS       = 16;
  localparam int unsigned FRAME_HALF_BITS = 40;
  localparam int unsigned BIT_RATE        = 1000000;

  localparam logic [SYNC_HALF_BITS-1:0] CMD_SYNC  = 6'b111000;
  localparam logic [SYNC_HALF_BITS-1:0] DATA_SYNC = 6'b000111;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Bit 39 is the first half-bit on the bus; 1 = H, 0 = L.
  function automatic logic [FRAME_HALF_BITS-1:0] manchester_frame(
    input logic [DATA_BITS-1:0] data,
    input logic                 cmd_sync
  );
    logic [FRAME_HALF_BITS-1:0] frame;
    frame = '0;
    frame[FRAME_HALF_BITS-1 -: SYNC_HALF_BITS] = cmd_sync ? CMD_SYNC : DATA_SYNC;
    for (int unsigned i = 0; i < DATA_BITS; i++) begin
      frame[2*(DATA_BITS-i) +: 2] = data[DATA_BITS-1-i] ? 2'b10 : 2'b01;
    end
    frame[1:0] = (~^data) ? 2'b10 : 2'b01;
    return frame;
  endfunction

endpackage

// File: rtl/mil1553_halfbit_tick.sv
// Half-bit strobe: tick marks the last clock of each HALF_BIT_CLKS-long half-bit.
module mil1553_halfbit_tick #(
  parameter int unsigned HALF_BIT_CLKS = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(HALF_BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((HALF_BIT_CLKS > 1) ? HALF_BIT_CLKS - 2 : 0);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);
  // pre_tick: the following clock is the last one of the current half-bit.
  assign pre_tick = (HALF_BIT_CLKS > 1) && (cnt == PRE_LAST);

endmodule

// File: rtl/mil1553_encoder.sv
// MIL-STD-1553 Manchester II transmitter: valid/ready word in, 40 half-bits out on tx_p/tx_n.
module mil1553_encoder
  import mil1553_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED = 12000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_data,
  input  logic        s_cmd_sync,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        tx_p,
  output logic        tx_n,
  output logic        tx_active
);

  localparam int unsigned HALF_BIT_CLKS = CLOCK_SPEED / (2 * BIT_RATE);
  localparam logic [5:0]  LAST_IDX      = 6'(FRAME_HALF_BITS - 1);

  if ((CLOCK_SPEED % (2 * BIT_RATE)) != 0 || HALF_BIT_CLKS < 1) begin : g_bad_clock
    $error("mil1553_encoder: CLOCK_SPEED must be a non-zero multiple of 2 MHz");
  end

  state_t                     state, state_next;
  logic [5:0]                 idx, idx_next;
  logic [FRAME_HALF_BITS-1:0] pattern, pattern_next, frame;
  logic                       p_next, n_next, active_next, ready_next;
  logic                       load, accept, tick, pre_tick, last_clk_next;

  mil1553_halfbit_tick #(
    .HALF_BIT_CLKS(HALF_BIT_CLKS)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (load),
    .en      (state == SEND),
    .tick    (tick),
    .pre_tick(pre_tick)
  );

  assign accept = s_valid && s_ready;
  assign frame  = manchester_frame(s_data, s_cmd_sync);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      pattern   <= '0;
      tx_p      <= 1'b0;
      tx_n      <= 1'b0;
      tx_active <= 1'b0;
      s_ready   <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      pattern   <= pattern_next;
      tx_p      <= p_next;
      tx_n      <= n_next;
      tx_active <= active_next;
      s_ready   <= ready_next;
    end
  end

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    pattern_next = pattern;
    p_next       = tx_p;
    n_next       = tx_n;
    active_next  = tx_active;
    load         = 1'b0;

    case (state)
      IDLE: begin
        if (accept) load = 1'b1;
      end
      SEND: begin
        if (tick) begin
          if (idx == LAST_IDX) begin
            if (accept) begin
              load = 1'b1;
            end else begin
              state_next   = IDLE;
              idx_next     = '0;
              pattern_next = '0;
              p_next       = 1'b0;
              n_next       = 1'b0;
              active_next  = 1'b0;
            end
          end else begin
            idx_next     = idx + 1'b1;
            pattern_next = {pattern[FRAME_HALF_BITS-2:0], 1'b0};
            p_next       = pattern[FRAME_HALF_BITS-2];
            n_next       = ~pattern[FRAME_HALF_BITS-2];
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (load) begin
      state_next   = SEND;
      idx_next     = '0;
      pattern_next = frame;
      p_next       = frame[FRAME_HALF_BITS-1];
      n_next       = ~frame[FRAME_HALF_BITS-1];
      active_next  = 1'b1;
    end

    // s_ready is registered, so predict whether the next clock closes half-bit 39.
    last_clk_next = tick ? (HALF_BIT_CLKS == 1) : pre_tick;
    ready_next    = (state_next == IDLE) || ((idx_next == LAST_IDX) && last_clk_next);
  end

endmodule

// File: tb/tb_mil1553_encoder.sv
// Randomised scoreboard bench for mil1553_encoder at 12 MHz and 2 MHz clock settings.
module tb_mil1553_encoder;

  typedef struct packed {
    logic p;
    logic last;
  } exp_t;

  logic             clk = 1'b0;
  logic [1:0]       rst;
  logic [1:0][15:0] s_data;
  logic [1:0]       s_cmd;
  logic [1:0]       s_valid;
  logic [1:0]       s_ready;
  logic [1:0]       tx_p;
  logic [1:0]       tx_n;
  logic [1:0]       tx_active;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_sb
    localparam int unsigned CS = (g == 0) ? 12000000 : 2000000;
    localparam int unsigned H  = CS / 2000000;

    exp_t q[$];
    bit   rcyc = 1'b0;

    mil1553_encoder #(
      .CLOCK_SPEED(CS)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .s_data    (s_data[g]),
      .s_cmd_sync(s_cmd[g]),
      .s_valid   (s_valid[g]),
      .s_ready   (s_ready[g]),
      .tx_p      (tx_p[g]),
      .tx_n      (tx_n[g]),
      .tx_active (tx_active[g])
    );

    // Reference: sync string, data MSB first as (bit, ~bit), odd-parity bit, each held H clocks.
    task automatic push_frame(input logic [15:0] d, input logic c);
      bit hb[$];
      int ones;
      for (int i = 0; i < 3; i++) hb.push_back(c);
      for (int i = 0; i < 3; i++) hb.push_back(!c);
      ones = 0;
      for (int i = 15; i >= 0; i--) begin
        hb.push_back(d[i]);
        hb.push_back(!d[i]);
        ones += int'(d[i]);
      end
      hb.push_back((ones % 2) == 0);
      hb.push_back((ones % 2) != 0);
      foreach (hb[k]) begin
        for (int j = 0; j < int'(H); j++) begin
          q.push_back('{p: hb[k], last: (k == hb.size() - 1) && (j == int'(H) - 1)});
        end
      end
    endtask

    always @(posedge clk) begin
      if (rst[g]) begin
        q.delete();
        rcyc = 1'b1;
      end else begin
        rcyc = 1'b0;
        if (s_valid[g] && s_ready[g]) push_frame(s_data[g], s_cmd[g]);
      end
    end

    always @(negedge clk) begin
      exp_t       e;
      logic [3:0] want, got;
      got = {tx_active[g], tx_p[g], tx_n[g], s_ready[g]};
      if (rcyc) begin
        want = 4'b0000;
      end else if (q.size() == 0) begin
        want = 4'b0001;
      end else begin
        e    = q.pop_front();
        want = {1'b1, e.p, !e.p, e.last};
      end
      total++;
      if (got === want) passed++;
      else $display("FAIL bus dut%0d t=%0t active/p/n/ready got %b required %b", g, $time, got, want);
    end
  end

  task automatic send(input int g, input logic [15:0] d, input logic c, input bit hold);
    int n;
    s_valid[g] = 1'b1;
    s_data[g]  = d;
    s_cmd[g]   = c;
    n = 0;
    while (s_ready[g] !== 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 1000) begin
      $display("FAIL handshake dut%0d s_ready got %b after %0d clocks required 1", g, s_ready[g], n);
      s_valid[g] = 1'b0;
    end else begin
      passed++;
      @(posedge clk); #1;
      if (!hold) begin
        s_valid[g] = 1'b0;
        s_data[g]  = 16'($urandom);
        s_cmd[g]   = 1'($urandom);
      end
    end
  endtask

  task automatic idle(input int g, input int n);
    repeat (n) begin
      s_data[g] = 16'($urandom);
      s_cmd[g]  = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic random_words(input int g, input int count, input int max_gap);
    bit hold;
    for (int i = 0; i < count; i++) begin
      hold = 1'($urandom);
      send(g, 16'($urandom), 1'($urandom), hold);
      if (!hold) idle(g, int'($urandom_range(0, max_gap)));
    end
    s_valid[g] = 1'b0;
  endtask

  initial begin
    rst     = 2'b11;
    s_valid = '0;
    s_data  = '0;
    s_cmd   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 2'b00;
    idle(0, 2);

    send(0, 16'hA5A5, 1'b1, 1'b0);
    idle(0, 250);
    send(0, 16'h0001, 1'b0, 1'b0);
    idle(0, 250);
    send(0, 16'($urandom), 1'b1, 1'b1);
    send(0, 16'($urandom), 1'b0, 1'b0);
    idle(0, 500);

    send(0, 16'h1234, 1'b1, 1'b0);
    idle(0, 20 * 6 + 2);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    idle(0, 3);
    send(0, 16'hBEEF, 1'b0, 1'b0);
    idle(0, 250);
    random_words(0, 10, 300);
    idle(0, 500);

    send(1, 16'hA5A5, 1'b1, 1'b0);
    idle(1, 45);
    send(1, 16'h0001, 1'b0, 1'b0);
    idle(1, 45);
    send(1, 16'hFFFF, 1'b1, 1'b1);
    send(1, 16'h0000, 1'b0, 1'b0);
    idle(1, 90);
    random_words(1, 12, 60);
    idle(1, 100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
